// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format codes, opcode constants and XLEN legality check
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_NONE  = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational instruction to immediate/format/illegal decode
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BJ_SCALED = 1
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  logic [31:0] w_imm32;
  logic        w_is_shift;

  // funct3 001 (sll) and 101 (srl/sra) share bits [13:12] = 01
  assign w_is_shift = (i_inst[13:12] == 2'b01);

  always_comb begin
    w_imm32   = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (i_inst[6:0])
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        o_fmt   = FMT_I;
        w_imm32 = 32'($signed(i_inst[31:20]));
      end
      OP_IMM: begin
        if (w_is_shift) begin
          o_fmt   = FMT_SHAMT;
          w_imm32 = (XLEN == 64) ? {26'd0, i_inst[25:20]} : {27'd0, i_inst[24:20]};
        end else begin
          o_fmt   = FMT_I;
          w_imm32 = 32'($signed(i_inst[31:20]));
        end
      end
      OP_IMM32: begin
        if (w_is_shift) begin
          o_fmt   = FMT_SHAMT;
          w_imm32 = {27'd0, i_inst[24:20]};
        end else begin
          o_fmt   = FMT_I;
          w_imm32 = 32'($signed(i_inst[31:20]));
        end
      end
      OP_STORE: begin
        o_fmt   = FMT_S;
        w_imm32 = 32'($signed({i_inst[31:25], i_inst[11:7]}));
      end
      OP_BRANCH: begin
        o_fmt   = FMT_B;
        w_imm32 = (BJ_SCALED != 0)
                ? 32'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}))
                : 32'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8]}));
      end
      OP_LUI, OP_AUIPC: begin
        o_fmt   = FMT_U;
        w_imm32 = {i_inst[31:12], 12'd0};
      end
      OP_JAL: begin
        o_fmt   = FMT_J;
        w_imm32 = (BJ_SCALED != 0)
                ? 32'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}))
                : 32'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21]}));
      end
      OP_OP, OP_OP32: begin
        o_fmt = FMT_R;
      end
      default: begin
        o_fmt     = FMT_NONE;
        o_illegal = 1'b1;
      end
    endcase
  end

  // Shift amounts have bit31 clear, so one signed widening covers every format
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator feeding a 2-entry skid FIFO
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BJ_SCALED = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_inst,
  output logic            out_illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] w_imm;
  imm_fmt_e        w_fmt;
  logic            w_illegal;
  logic            w_push;
  logic            w_pop;

  logic [XLEN-1:0] r_imm  [2];
  imm_fmt_e        r_fmt  [2];
  logic [31:0]     r_inst [2];
  logic            r_ill  [2];
  logic            r_wr;
  logic            r_rd;
  logic [1:0]      r_count;
  logic            r_init;

  imm_decode #(.XLEN(XLEN), .BJ_SCALED(BJ_SCALED)) u_decode (
    .i_inst    (in_inst),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  // r_init holds in_ready low until the first edge after reset releases
  assign in_ready  = r_init && (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_imm[i]  <= '0;
        r_fmt[i]  <= FMT_NONE;
        r_inst[i] <= '0;
        r_ill[i]  <= 1'b0;
      end
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_count <= 2'd0;
      r_init  <= 1'b0;
    end else begin
      r_init <= 1'b1;
      if (flush) begin
        r_wr    <= 1'b0;
        r_rd    <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_push) begin
          r_imm[r_wr]  <= w_imm;
          r_fmt[r_wr]  <= w_fmt;
          r_inst[r_wr] <= in_inst;
          r_ill[r_wr]  <= w_illegal;
          r_wr         <= ~r_wr;
        end
        if (w_pop) begin
          r_rd <= ~r_rd;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign out_imm     = r_imm[r_rd];
  assign out_fmt     = r_fmt[r_rd];
  assign out_inst    = r_inst[r_rd];
  assign out_illegal = r_ill[r_rd];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_inst;

  logic        in_ready_32, out_valid_32, out_illegal_32;
  logic [31:0] out_imm_32;
  logic [2:0]  out_fmt_32;
  logic [31:0] out_inst_32;

  logic        in_ready_h, out_valid_h, out_illegal_h;
  logic [63:0] out_imm_h;
  logic [2:0]  out_fmt_h;
  logic [31:0] out_inst_h;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_inst(out_inst), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .BJ_SCALED(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
    .in_inst(in_inst), .out_valid(out_valid_32), .out_ready(out_ready), .out_imm(out_imm_32),
    .out_fmt(out_fmt_32), .out_inst(out_inst_32), .out_illegal(out_illegal_32)
  );

  imm_gen_pipe #(.XLEN(64), .BJ_SCALED(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_h),
    .in_inst(in_inst), .out_valid(out_valid_h), .out_ready(out_ready), .out_imm(out_imm_h),
    .out_fmt(out_fmt_h), .out_inst(out_inst_h), .out_illegal(out_illegal_h)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_fmt !== 3'd7) begin bad++; $display("FAIL rst_out_fmt got=%0d exp=7", out_fmt); end
    total++; if (out_imm !== 64'd0) begin bad++; $display("FAIL rst_out_imm got=%h exp=0", out_imm); end
    total++; if (out_inst !== 32'd0) begin bad++; $display("FAIL rst_out_inst got=%h exp=0", out_inst); end
    total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL rst_out_illegal got=%0b exp=0", out_illegal); end
    cyc(2);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_hold_in_ready got=%0b exp=0", in_ready); end
    rst_n = 1'b1;
    cyc();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_out_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] v_inst [12] = '{32'hFFF00093, 32'h800000B7, 32'hFE000EE3, 32'h03F09093,
                                 32'h01F0909B, 32'h0000007F, 32'h00000033, 32'hFE000E23,
                                 32'h0010006F, 32'hFFFFF06F, 32'h40105093, 32'h00001017};
    logic [2:0]  v_fmt  [12] = '{3'd1, 3'd4, 3'd3, 3'd6, 3'd6, 3'd7, 3'd0, 3'd2, 3'd5, 3'd5, 3'd6, 3'd4};
    logic        v_ill  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [63:0] v_i64  [12] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
                                 64'h3F, 64'h1F, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                                 64'h800, 64'hFFFFFFFFFFFFFFFE, 64'h1, 64'h1000};
    logic [31:0] v_i32  [12] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFC, 32'h1F, 32'h1F, 32'h0,
                                 32'h0, 32'hFFFFFFFC, 32'h800, 32'hFFFFFFFE, 32'h1, 32'h1000};
    logic [63:0] v_ih   [12] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFE,
                                 64'h3F, 64'h1F, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                                 64'h400, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h1000};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_inst  = v_inst[i];
      cyc();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dec%0d_valid got=%0b exp=1", i, out_valid); end
      total++; if (out_inst !== v_inst[i]) begin bad++; $display("FAIL dec%0d_inst got=%h exp=%h", i, out_inst, v_inst[i]); end
      total++; if (out_fmt !== v_fmt[i]) begin bad++; $display("FAIL dec%0d_fmt got=%0d exp=%0d", i, out_fmt, v_fmt[i]); end
      total++; if (out_illegal !== v_ill[i]) begin bad++; $display("FAIL dec%0d_illegal got=%0b exp=%0b", i, out_illegal, v_ill[i]); end
      total++; if (out_imm !== v_i64[i]) begin bad++; $display("FAIL dec%0d_imm64 got=%h exp=%h", i, out_imm, v_i64[i]); end
      total++; if (out_imm_32 !== v_i32[i]) begin bad++; $display("FAIL dec%0d_imm32 got=%h exp=%h", i, out_imm_32, v_i32[i]); end
      total++; if (out_fmt_32 !== v_fmt[i]) begin bad++; $display("FAIL dec%0d_fmt32 got=%0d exp=%0d", i, out_fmt_32, v_fmt[i]); end
      total++; if (out_imm_h !== v_ih[i]) begin bad++; $display("FAIL dec%0d_imm_half got=%h exp=%h", i, out_imm_h, v_ih[i]); end
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dec%0d_drained got=%0b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v_inst [4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_inst  = v_inst[k];
      cyc();
      total++; if (out_inst !== v_inst[k]) begin bad++; $display("FAIL b2b%0d_inst got=%h exp=%h", k, out_inst, v_inst[k]); end
      total++; if (out_imm !== 64'(k + 1)) begin bad++; $display("FAIL b2b%0d_imm got=%h exp=%0d", k, out_imm, k + 1); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready got=%0b exp=1", k, in_ready); end
    end
    in_valid = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00500093;
    cyc();
    in_inst = 32'h00600093;
    cyc();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
    in_inst = 32'h00700093;
    cyc();
    in_valid = 1'b0;
    total++; if (out_inst !== 32'h00500093) begin bad++; $display("FAIL bp_head got=%h exp=00500093", out_inst); end
    cyc(2);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%0b exp=1", out_valid); end
    total++; if (out_imm !== 64'd5) begin bad++; $display("FAIL bp_hold_imm got=%h exp=5", out_imm); end
    out_ready = 1'b1;
    cyc();
    total++; if (out_inst !== 32'h00600093) begin bad++; $display("FAIL bp_second got=%h exp=00600093", out_inst); end
    total++; if (out_imm !== 64'd6) begin bad++; $display("FAIL bp_second_imm got=%h exp=6", out_imm); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_back got=%0b exp=1", in_ready); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00800093;
    cyc();
    in_inst = 32'h00900093;
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fl_pre_valid got=%0b exp=1", out_valid); end
    in_inst = 32'h00A00093;
    flush   = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fl_in_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_push_dropped got=%0b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%0b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_imm !== 64'd0) begin bad++; $display("FAIL ar_out_imm got=%h exp=0", out_imm); end
    total++; if (out_fmt !== 3'd7) begin bad++; $display("FAIL ar_out_fmt got=%0d exp=7", out_fmt); end
    total++; if (out_inst !== 32'd0) begin bad++; $display("FAIL ar_out_inst got=%h exp=0", out_inst); end
    cyc();
    rst_n = 1'b1;
    cyc();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_release_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_entry_lost got=%0b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter BJ_SCALED, default 1: 1 = B/J immediates are byte offsets with bit0=0; 0 = halfword units (offset>>1, sign-preserving).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  discard all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port in_ready  output  1  block can accept.
REQ-008 SHALL have port in_inst  input  32  raw instruction.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts.
REQ-011 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-012 SHALL have port out_fmt  output  3  format code (see REQ-019).
REQ-013 SHALL have port out_inst  output  32  instruction passthrough.
REQ-014 SHALL have port out_illegal  output  1  opcode not recognised.

Function
REQ-015 SHALL decode from in_inst[6:0]: I = 0000011, 0010011, 0011011, 1100111, 1110011; S = 0100011; B = 1100011; U = 0110111, 0010111; J = 1101111; R = 0110011, 0111011.
REQ-016 SHALL sign-extend every I/S/B/U/J immediate from inst[31] to XLEN; U = inst[31:12]<<12, sign-extended when XLEN=64.
REQ-017 SHALL treat opcode 0010011 with funct3 001/101 as SHAMT: imm = zero-extended inst[25:20] at XLEN=64, inst[24:20] at XLEN=32; opcode 0011011 funct3 001/101 as SHAMT with inst[24:20].
REQ-018 SHALL output imm=0 for R; imm=0 and out_illegal=1 for any other opcode (fmt NONE).
REQ-019 SHALL encode out_fmt: R=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, NONE=7.
REQ-020 SHALL decode combinationally on input and register the result: latency exactly 1 cycle from accept to out_valid when the buffer was empty.
REQ-021 SHALL buffer in a 2-entry FIFO (skid buffer); in_ready = (count<2), driven from registers only, no combinational path from out_ready.
REQ-022 SHALL accept on in_valid&&in_ready, pop on out_valid&&out_ready; simultaneous push and pop keep count unchanged; sustained throughput 1 per cycle.
REQ-023 SHALL preserve order; out_* SHALL hold stable while out_valid&&!out_ready.
REQ-024 SHALL on flush clear count to 0 at the next edge; a push in the flush cycle SHALL be dropped; out_valid=0 the cycle after flush.
REQ-025 SHALL make out_imm/out_fmt/out_illegal a pure function of out_inst and parameters.

Reset
REQ-026 SHALL on rst_n low asynchronously set count=0, out_valid=0, in_ready=0 while asserted; out_imm=0, out_fmt=7, out_inst=0, out_illegal=0.
REQ-027 SHALL assert in_ready the first edge after rst_n deasserts; entries in flight at reset SHALL be lost.

Structure
REQ-028 SHALL place format codes, opcode constants and XLEN legality check in shared package imm_pkg.
REQ-029 SHALL use one sub-module imm_decode (combinational inst->imm/fmt/illegal), instantiated once at the input.

Verification
REQ-030 addi 0xFFF00093, XLEN=64 -> imm 0xFFFFFFFFFFFFFFFF, fmt 1, one cycle after accept.
REQ-031 lui 0x800000B7 -> imm 0xFFFFFFFF80000000 (XLEN=64), 0x80000000 (XLEN=32), fmt 4.
REQ-032 beq 0xFE000EE3 -> BJ_SCALED=1 imm 0xFFFFFFFFFFFFFFFC; BJ_SCALED=0 imm 0xFFFFFFFFFFFFFFFE; fmt 3.
REQ-033 slli 0x03F09093 -> fmt 6 imm 0x3F; slliw 0x01F0909B -> imm 0x1F; opcode 0x7F -> fmt 7, illegal 1.
REQ-034 out_ready=0, push 3 back-to-back -> 2 accepted, in_ready low, then out_ready=1 -> both drained in order, no loss.
REQ-035 2 entries held, flush pulse with in_valid=1 -> out_valid 0 next cycle, pushed entry dropped; rst_n low mid-stream -> outputs at reset values immediately.
